// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit stability counter for board slide switches.
// sw_db only takes a new level after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module switch_debouncer #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] changed,
  output logic             stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_reg;
  logic [WIDTH-1:0]            s2_reg;
  logic [WIDTH-1:0]            sw_db_reg;
  logic [WIDTH-1:0]            sw_db_next;
  logic [WIDTH-1:0]            changed_reg;
  logic [WIDTH-1:0]            changed_next;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_next;
  logic                        stable_reg;
  logic                        stable_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic mismatch;
      logic at_max;

      assign mismatch = s2_reg[gi] ^ sw_db_reg[gi];
      assign at_max   = (cnt_reg[gi] == CNT_MAX);

      // A matching sample clears the count, so a glitch mid-count restarts qualification.
      assign cnt_next[gi]     = (mismatch && !at_max) ? cnt_reg[gi] + CNT_W'(1) : '0;
      assign sw_db_next[gi]   = (mismatch && at_max) ? s2_reg[gi] : sw_db_reg[gi];
      assign changed_next[gi] = mismatch && at_max;
    end
  endgenerate

  // s1_reg is what s2_reg will hold after this edge.
  assign stable_next = (cnt_next == '0) && (s1_reg == sw_db_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg      <= '0;
      s2_reg      <= '0;
      sw_db_reg   <= '0;
      changed_reg <= '0;
      cnt_reg     <= '0;
      stable_reg  <= 1'b1;
    end else begin
      s1_reg      <= sw_in;
      s2_reg      <= s1_reg;
      sw_db_reg   <= sw_db_next;
      changed_reg <= changed_next;
      cnt_reg     <= cnt_next;
      stable_reg  <= stable_next;
    end
  end

  assign sw_db   = sw_db_reg;
  assign changed = changed_reg;
  assign stable  = stable_reg;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (WIDTH=3, DEBOUNCE_CYCLES=4): vector table plus
// hand-written multi-cycle sequences. Step n means the sample 1 ns after the n-th edge.
module tb_switch_debouncer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw_in = 3'b000;
  logic [2:0] sw_db;
  logic [2:0] changed;
  logic       stable;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst;
    logic [2:0] sw;
    logic [2:0] db;
    logic [2:0] chg;
    logic       st;
  } vec_t;

  vec_t vecs[$];

  switch_debouncer #(.WIDTH(3), .DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .sw_in  (sw_in),
    .sw_db  (sw_db),
    .changed(changed),
    .stable (stable)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic d_of(input logic [2:0] v);
    return v[2] | (v[1] & v[0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] s, input string tag);
    rst   = r;
    sw_in = s;
    @(posedge clk);
    #1;
    $display("%s: rst=%0b sw_in=%b -> sw_db=%b changed=%b stable=%0b",
             tag, r, s, sw_db, changed, stable);
  endtask

  task automatic expect3(input string tag, input logic [2:0] db, input logic [2:0] chg,
                         input logic st);
    chk({tag, " sw_db"}, {29'b0, sw_db}, {29'b0, db});
    chk({tag, " changed"}, {29'b0, changed}, {29'b0, chg});
    chk({tag, " stable"}, {31'b0, stable}, {31'b0, st});
  endtask

  task automatic add(input logic r, input logic [2:0] s, input logic [2:0] db,
                     input logic [2:0] chg, input logic st);
    vec_t v;
    v.rst = r; v.sw = s; v.db = db; v.chg = chg; v.st = st;
    vecs.push_back(v);
  endtask

  // Seven steps of a clean qualified transition from 'from' to sw held at 'to'.
  task automatic add_run(input logic [2:0] from, input logic [2:0] to);
    add(1'b0, to, from, 3'b000, 1'b1);
    for (int n = 2; n <= 5; n++) add(1'b0, to, from, 3'b000, 1'b0);
    add(1'b0, to, to, from ^ to, 1'b1);
    add(1'b0, to, to, 3'b000, 1'b1);
  endtask

  initial begin
    // Reset with switches high, re-qualify after release, fall back, then clean step to 101.
    add(1'b1, 3'b111, 3'b000, 3'b000, 1'b1);
    add(1'b1, 3'b111, 3'b000, 3'b000, 1'b1);
    add_run(3'b000, 3'b111);
    add_run(3'b111, 3'b000);
    add_run(3'b000, 3'b101);

    foreach (vecs[k]) begin
      step(vecs[k].rst, vecs[k].sw, $sformatf("vec%0d", k));
      expect3($sformatf("vec%0d", k), vecs[k].db, vecs[k].chg, vecs[k].st);
    end
    chk("clean_step D", {31'b0, d_of(sw_db)}, 32'd1);

    // Bounce on bit1: 0,1,0,1,0 at 2 cycles each, then hold 0.
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b0, {1'b1, p[0], 1'b1}, $sformatf("bounce%0d", p * 2 + c));
        chk("bounce sw_db", {29'b0, sw_db}, 32'h5);
        chk("bounce changed", {29'b0, changed}, 32'h0);
      end
    end
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 3'b101, "bounce_hold");
      chk("bounce_hold sw_db", {29'b0, sw_db}, 32'h5);
      chk("bounce_hold changed", {29'b0, changed}, 32'h0);
    end
    chk("bounce stable", {31'b0, stable}, 32'd1);

    // Threshold on bit0: 3-cycle pulse rejected, 4-cycle pulse accepted.
    for (int c = 0; c < 8; c++) step(1'b0, 3'b000, "settle");
    chk("settle sw_db", {29'b0, sw_db}, 32'h0);
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, (n <= 3) ? 3'b001 : 3'b000, $sformatf("pulse3_%0d", n));
      chk("pulse3 sw_db", {29'b0, sw_db}, 32'h0);
      chk("pulse3 changed", {29'b0, changed}, 32'h0);
    end
    for (int n = 1; n <= 12; n++) begin
      step(1'b0, (n <= 4) ? 3'b001 : 3'b000, $sformatf("pulse4_%0d", n));
      chk($sformatf("pulse4 sw_db n=%0d", n), {29'b0, sw_db},
          (n >= 6 && n <= 9) ? 32'h1 : 32'h0);
      chk($sformatf("pulse4 changed n=%0d", n), {29'b0, changed},
          (n == 6 || n == 10) ? 32'h1 : 32'h0);
    end

    // Independent bits: bit2 from step 1, bit0 from step 3.
    for (int n = 1; n <= 10; n++) begin
      logic [2:0] edb, echg;
      edb  = ((n >= 6) ? 3'b100 : 3'b000) | ((n >= 8) ? 3'b001 : 3'b000);
      echg = (n == 6) ? 3'b100 : ((n == 8) ? 3'b001 : 3'b000);
      step(1'b0, (n >= 3) ? 3'b101 : 3'b100, $sformatf("indep%0d", n));
      expect3($sformatf("indep n=%0d", n), edb, echg, (n == 1) || (n >= 8));
    end

    // Reset mid-count on bit1: progress discarded, re-qualified after release.
    for (int c = 0; c < 8; c++) step(1'b0, 3'b000, "settle");
    chk("settle2 sw_db", {29'b0, sw_db}, 32'h0);
    for (int n = 1; n <= 11; n++) begin
      step(n == 4, 3'b010, $sformatf("rstmid%0d", n));
      expect3($sformatf("rstmid n=%0d", n), (n >= 10) ? 3'b010 : 3'b000,
              (n == 10) ? 3'b010 : 3'b000, (n == 1) || (n == 4) || (n == 5) || (n >= 10));
    end

    // Sweep every switch combination and check the downstream D = A | (B & C).
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < 10; c++) step(1'b0, i[2:0], $sformatf("sweep%0d", i));
      chk($sformatf("sweep%0d sw_db", i), {29'b0, sw_db}, i);
      chk($sformatf("sweep%0d D", i), {31'b0, d_of(sw_db)},
          {31'b0, (i[2] | (i[1] & i[0]))});
      chk($sformatf("sweep%0d stable", i), {31'b0, stable}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
